// File: rtl/plate_digit_stabilizer.sv
// plate_digit_stabilizer: per-frame temporal filter for recognised plate digits.
// A plate is declared only after the same fully recognised digit word has been
// seen on STABLE_FRAMES consecutive frames. Confirmed plates go into a small
// circular history.
// Optional feature macro: PLATE_STAB_HIST_EN builds the history RAM and its read
// port. Without it, new_plate compares against the last locked plate only.
module plate_digit_stabilizer #(
  parameter int DIGITS        = 6,
  parameter int STABLE_FRAMES = 4,
  parameter int MISS_FRAMES   = 8,
  parameter int HIST_DEPTH    = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_vsync,
  input  logic [4*DIGITS-1:0]           digit_in,
  output logic [4*DIGITS-1:0]           stable_digit,
  output logic                          stable_valid,
  output logic                          new_plate,
  output logic                          locked,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_rd_idx,
  output logic [4*DIGITS-1:0]           hist_rd_data,
  output logic [$clog2(HIST_DEPTH):0]   hist_count
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = $clog2(HIST_DEPTH);
  localparam logic [W-1:0] ONES     = {W{1'b1}};
  localparam logic [3:0]   STABLE_C = 4'(STABLE_FRAMES);
  localparam logic [3:0]   MISS_C   = 4'(MISS_FRAMES);

  typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, LOCKED = 2'd2} state_t;

  // A digit word is usable only when every nibble was recognised.
  function automatic logic all_recognised(input logic [W-1:0] w);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (w[4*i +: 4] == 4'hF) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  state_t         state_q, state_d;
  logic [W-1:0]   cand_q, cand_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [3:0]     miss_q, miss_d;
  logic           vs_q;
  logic           arm_q;      // set once vsync has been seen low since reset
  logic [W-1:0]   stable_digit_q;
  logic           stable_valid_q, new_plate_q, locked_q;
  logic           tick_s, valid_s, lock_s, new_s;

  // arm_q blocks a tick from a vsync that was already high when reset released.
  assign tick_s  = frame_vsync & ~vs_q & arm_q;
  assign valid_s = all_recognised(digit_in);

  // Next-state logic; the FSM only moves on a frame tick.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    miss_d  = miss_q;
    lock_s  = 1'b0;
    if (tick_s) begin
      case (state_q)
        IDLE: begin
          if (valid_s) begin
            cand_d  = digit_in;
            cnt_d   = 4'd1;
            state_d = TRACK;
          end else begin
            state_d = IDLE;
          end
        end
        TRACK: begin
          if (digit_in == cand_q) begin
            cnt_d = cnt_q + 4'd1;
            if ((cnt_q + 4'd1) == STABLE_C) begin
              lock_s  = 1'b1;
              miss_d  = 4'd0;
              state_d = LOCKED;
            end else begin
              state_d = TRACK;
            end
          end else if (valid_s) begin
            cand_d = digit_in;
            cnt_d  = 4'd1;
          end else begin
            cnt_d   = 4'd0;
            state_d = IDLE;
          end
        end
        LOCKED: begin
          if (digit_in == stable_digit_q) begin
            miss_d = 4'd0;
          end else begin
            miss_d = miss_q + 4'd1;
            if ((miss_q + 4'd1) == MISS_C) begin
              cnt_d   = 4'd0;
              state_d = IDLE;
            end else begin
              state_d = LOCKED;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // FSM state, frame-edge detector and registered lock outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cand_q         <= ONES;
      cnt_q          <= 4'd0;
      miss_q         <= 4'd0;
      vs_q           <= 1'b0;
      arm_q          <= 1'b0;
      stable_digit_q <= ONES;
      stable_valid_q <= 1'b0;
      new_plate_q    <= 1'b0;
      locked_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      cand_q         <= cand_d;
      cnt_q          <= cnt_d;
      miss_q         <= miss_d;
      vs_q           <= frame_vsync;
      arm_q          <= arm_q | ~frame_vsync;
      stable_digit_q <= lock_s ? cand_q : stable_digit_q;
      stable_valid_q <= lock_s;
      new_plate_q    <= lock_s & new_s;
      locked_q       <= (state_d == LOCKED);
    end
  end

  assign stable_digit = stable_digit_q;
  assign stable_valid = stable_valid_q;
  assign new_plate    = new_plate_q;
  assign locked       = locked_q;

`ifdef PLATE_STAB_HIST_EN
  localparam logic [PW:0]   COUNT_MAX = (PW+1)'(HIST_DEPTH);
  localparam logic [PW:0]   COUNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  logic [W-1:0]  mem_q [HIST_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW:0]   count_q;
  logic [W-1:0]  rd_data_q;
  logic [W-1:0]  newest_s;
  logic          wr_s;

  assign newest_s = mem_q[wr_ptr_q - PTR_ONE];
  assign new_s    = (count_q == {(PW+1){1'b0}}) || (cand_q != newest_s);
  assign wr_s     = lock_s & new_s;

  // History storage; validity is tracked by count_q, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_q[wr_ptr_q] <= cand_q;
    end
  end

  // Write pointer, fill count and registered read port (reads see pre-write data).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= {PW{1'b0}};
      count_q   <= {(PW+1){1'b0}};
      rd_data_q <= ONES;
    end else begin
      if (wr_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
        count_q  <= (count_q == COUNT_MAX) ? count_q : count_q + COUNT_ONE;
      end
      if ({1'b0, hist_rd_idx} >= count_q) begin
        rd_data_q <= ONES;
      end else begin
        rd_data_q <= mem_q[wr_ptr_q - PTR_ONE - hist_rd_idx];
      end
    end
  end

  assign hist_rd_data = rd_data_q;
  assign hist_count   = count_q;
`else
  logic unused_idx_s;

  // stable_digit_q only changes on a lock, so it is the last-locked plate.
  assign new_s        = (cand_q != stable_digit_q);
  assign unused_idx_s = ^hist_rd_idx;
  assign hist_rd_data = ONES;
  assign hist_count   = {(PW+1){1'b0}};
`endif

endmodule

// File: tb/tb_plate_digit_stabilizer.sv
// Directed bench for plate_digit_stabilizer; history checks follow PLATE_STAB_HIST_EN.
module tb_plate_digit_stabilizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_vsync = 1'b0;
  logic [23:0] digit_in = 24'h0;
  logic [23:0] stable_digit;
  logic        stable_valid, new_plate, locked;
  logic [2:0]  hist_rd_idx = 3'd0;
  logic [23:0] hist_rd_data;
  logic [3:0]  hist_count;

  int n_vec = 0;
  int n_err = 0;
  logic sv_s, np_s;
  logic [23:0] rd_s;

`ifdef PLATE_STAB_HIST_EN
  localparam bit HIST = 1'b1;
`else
  localparam bit HIST = 1'b0;
`endif

  plate_digit_stabilizer dut (
    .clk(clk), .rst_n(rst_n), .frame_vsync(frame_vsync), .digit_in(digit_in),
    .stable_digit(stable_digit), .stable_valid(stable_valid), .new_plate(new_plate),
    .locked(locked), .hist_rd_idx(hist_rd_idx), .hist_rd_data(hist_rd_data),
    .hist_count(hist_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One frame: vsync rise with data d; pulses captured right after the tick edge.
  // Between ticks digit_in is set to a valid but different word that must be ignored.
  task automatic frame(input logic [23:0] d);
    @(negedge clk);
    digit_in = d;
    frame_vsync = 1'b1;
    @(posedge clk);
    #1;
    sv_s = stable_valid;
    np_s = new_plate;
    @(negedge clk);
    frame_vsync = 1'b0;
    digit_in = 24'h000000;
    @(negedge clk);
  endtask

  task automatic frames(input logic [23:0] d, input int n);
    for (int k = 0; k < n; k++) frame(d);
  endtask

  task automatic rd(input logic [2:0] idx);
    @(negedge clk);
    hist_rd_idx = idx;
    @(posedge clk);
    #1;
    rd_s = hist_rd_data;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".digit"}, 32'(stable_digit), 32'hFFFFFF);
    check({tag, ".sv"},    32'(stable_valid), 32'd0);
    check({tag, ".np"},    32'(new_plate), 32'd0);
    check({tag, ".locked"}, 32'(locked), 32'd0);
    check({tag, ".count"}, 32'(hist_count), 32'd0);
    check({tag, ".rddata"}, 32'(hist_rd_data), 32'hFFFFFF);
  endtask

  initial begin
    // Reset state
    do_reset();
    #1;
    check_reset_state("rst");

    // Basic lock on the 4th tick
    frames(24'h564893, 3);
    check("t1.sv3", 32'(sv_s), 32'd0);
    check("t1.lk3", 32'(locked), 32'd0);
    frame(24'h564893);
    check("t1.sv4", 32'(sv_s), 32'd1);
    check("t1.np4", 32'(np_s), 32'd1);
    check("t1.digit", 32'(stable_digit), 32'h564893);
    check("t1.locked", 32'(locked), 32'd1);
    check("t1.sv_off", 32'(stable_valid), 32'd0);
    check("t1.count", 32'(hist_count), HIST ? 32'd1 : 32'd0);
    rd(3'd0);
    check("t1.idx0", 32'(rd_s), HIST ? 32'h564893 : 32'hFFFFFF);
    rd(3'd1);
    check("t1.idx1", 32'(rd_s), 32'hFFFFFF);
    rd(3'd7);
    check("t1.idx7", 32'(rd_s), 32'hFFFFFF);

    // Invalid frame breaks tracking
    do_reset();
    frames(24'h564893, 3);
    frame(24'h56489F);
    frames(24'h564893, 3);
    check("t2.sv3", 32'(sv_s), 32'd0);
    check("t2.lk3", 32'(locked), 32'd0);
    frame(24'h564893);
    check("t2.sv4", 32'(sv_s), 32'd1);
    check("t2.lk4", 32'(locked), 32'd1);

    // Miss counting while locked
    frames(24'hFFFFFF, 7);
    check("t3.lk7", 32'(locked), 32'd1);
    frame(24'hFFFFFF);
    check("t3.lk8", 32'(locked), 32'd0);
    check("t3.digit", 32'(stable_digit), 32'h564893);

    // Duplicate re-lock
    do_reset();
    frames(24'h111111, 4);
    check("t4.np1", 32'(np_s), 32'd1);
    frames(24'hFFFFFF, 8);
    check("t4.drop", 32'(locked), 32'd0);
    frames(24'h111111, 4);
    check("t4.sv", 32'(sv_s), 32'd1);
    check("t4.np", 32'(np_s), 32'd0);
    check("t4.count", 32'(hist_count), HIST ? 32'd1 : 32'd0);
    frames(24'hFFFFFF, 8);
    frames(24'h222222, 4);
    check("t4.np_new", 32'(np_s), 32'd1);
    check("t4.count2", 32'(hist_count), HIST ? 32'd2 : 32'd0);

    // Wrap-around with 9 distinct plates
    do_reset();
    for (int p = 1; p <= 9; p++) begin
      frames(24'(p), 4);
      check($sformatf("t5.np%0d", p), 32'(np_s), 32'd1);
      frames(24'hFFFFFF, 8);
    end
    check("t5.count", 32'(hist_count), HIST ? 32'd8 : 32'd0);
    rd(3'd0);
    check("t5.idx0", 32'(rd_s), HIST ? 32'h000009 : 32'hFFFFFF);
    rd(3'd7);
    check("t5.idx7", 32'(rd_s), HIST ? 32'h000002 : 32'hFFFFFF);
    rd(3'd3);
    check("t5.idx3", 32'(rd_s), HIST ? 32'h000006 : 32'hFFFFFF);

    // Reset mid-TRACK, with vsync held high across reset release
    frames(24'h777777, 3);
    @(negedge clk);
    digit_in = 24'h777777;
    frame_vsync = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_state("t6");
    repeat (3) @(negedge clk);
    frame_vsync = 1'b0;
    @(negedge clk);
    frames(24'h777777, 3);
    check("t6.sv3", 32'(sv_s), 32'd0);
    check("t6.lk3", 32'(locked), 32'd0);
    frame(24'h777777);
    check("t6.sv4", 32'(sv_s), 32'd1);
    check("t6.digit", 32'(stable_digit), 32'h777777);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
